// File: rtl/vco_555_pkg.sv
// vco_555_pkg: shared types, constants and coefficient helper for the multi-channel 555 VCO
package vco_555_pkg;
  typedef enum logic {CHARGE, DISCHARGE} chan_state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int K_W = 16;
  // K = dt/(R*C) in Q0.16 with dt = 1/sample_rate; C is given in nanofarads
  function automatic logic [K_W-1:0] k_from_rc(input longint sample_rate, input longint r_ohm, input longint c_nf);
    longint d;
    longint k;
    d = sample_rate * r_ohm * c_nf;
    k = (d == 0) ? 64'd65535 : ((longint'(1) << K_W) * longint'(1_000_000_000)) / d;
    return (k > 65535) ? 16'hffff : K_W'(k);
  endfunction
endpackage

// File: rtl/vco_555_slot_update.sv
// vco_555_slot_update: combinational one-channel charge/discharge step shared by all channels
module vco_555_slot_update
  import vco_555_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC = 8,
  parameter logic [K_W-1:0] K_CHARGE = 16'd2048,
  parameter logic [K_W-1:0] K_DISCHARGE = 16'd4096
) (
  input  logic [WIDTH+FRAC-1:0] v,
  input  chan_state_t           st,
  input  logic [WIDTH-1:0]      v_control,
  input  logic                  en,
  output logic [WIDTH+FRAC-1:0] v_next,
  output chan_state_t           st_next,
  output logic [WIDTH-1:0]      sample
);
  localparam int VW = WIDTH + FRAC;
  localparam int PW = VW + K_W;
  localparam logic [VW-1:0] VMAX = '1;
  logic [PW-1:0] up_prod, dn_prod;
  logic [VW-1:0] up_step, dn_step, v_up, v_dn, upper, lower;
  logic [VW:0] up_sum;
  assign up_prod = PW'(VMAX - v) * PW'(K_CHARGE);
  assign dn_prod = PW'(v) * PW'(K_DISCHARGE);
  assign up_step = VW'(up_prod >> K_W);
  assign dn_step = VW'(dn_prod >> K_W);
  assign up_sum = {1'b0, v} + {1'b0, up_step};
  assign v_up = up_sum[VW] ? VMAX : up_sum[VW-1:0];
  assign v_dn = (dn_step > v) ? '0 : v - dn_step;
  assign upper = VW'(v_control) << FRAC;
  assign lower = upper >> 1;
  // zero control forces a decay; otherwise thresholds are tested against the updated voltage
  always_comb begin
    v_next = '0;
    st_next = CHARGE;
    if (en && v_control == '0) begin
      v_next = v_dn;
      st_next = DISCHARGE;
    end else if (en && st == CHARGE) begin
      v_next = v_up;
      st_next = (v_up >= upper) ? DISCHARGE : CHARGE;
    end else if (en) begin
      v_next = v_dn;
      st_next = (v_dn <= lower) ? CHARGE : DISCHARGE;
    end
  end
  assign sample = (en && st_next == CHARGE) ? {1'b0, {(WIDTH-1){1'b1}}} : '0;
endmodule

// File: rtl/astable_555_vco_multi.sv
// astable_555_vco_multi: time-multiplexed bank of 555 astable VCOs; VCO_CAP_OUT_EN adds cap_out
module astable_555_vco_multi
  import vco_555_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int FRAC = 8,
  parameter int CLOCK_RATE = 1000000,
  parameter int SAMPLE_RATE = 48000,
  parameter logic [K_W-1:0] K_CHARGE = 16'd2048,
  parameter logic [K_W-1:0] K_DISCHARGE = 16'd4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      audio_clk_en,
  input  logic [CHANNELS-1:0]       chan_enable,
  input  logic [CHANNELS*WIDTH-1:0] v_control,
  output logic [CHANNELS*WIDTH-1:0] out,
`ifdef VCO_CAP_OUT_EN
  output logic [CHANNELS*WIDTH-1:0] cap_out,
`endif
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);
  localparam int VW = WIDTH + FRAC;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  if (CHANNELS < 1 || CHANNELS > 16 || CLOCK_RATE < SAMPLE_RATE * (CHANNELS + 3)) begin : g_param_check
    $error("astable_555_vco_multi: CHANNELS or clock/sample rate out of range");
  end
  seq_state_t seq, seq_next;
  logic [IW-1:0] idx;
  logic last;
  logic [VW-1:0] v_r [CHANNELS];
  chan_state_t st_r [CHANNELS];
  logic [WIDTH-1:0] vc_a [CHANNELS];
  logic [WIDTH-1:0] stage [CHANNELS];
  logic [WIDTH-1:0] out_a [CHANNELS];
  logic [VW-1:0] v_next;
  chan_state_t st_next;
  logic [WIDTH-1:0] sample;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign vc_a[g] = v_control[g*WIDTH +: WIDTH];
    assign out[g*WIDTH +: WIDTH] = out_a[g];
  end
  assign last = idx == IW'(CHANNELS - 1);
  assign busy = seq == RUN;
  assign out_valid = seq == DONE;
  vco_555_slot_update #(
    .WIDTH(WIDTH),
    .FRAC(FRAC),
    .K_CHARGE(K_CHARGE),
    .K_DISCHARGE(K_DISCHARGE)
  ) u_slot (
    .v(v_r[idx]),
    .st(st_r[idx]),
    .v_control(vc_a[idx]),
    .en(chan_enable[idx]),
    .v_next(v_next),
    .st_next(st_next),
    .sample(sample)
  );
  // sequencer state register
  always_ff @(posedge clk or posedge reset)
    if (reset) seq <= IDLE;
    else seq <= seq_next;
  // IDLE waits for the strobe, RUN walks every channel slot, DONE publishes for one cycle
  always_comb begin
    seq_next = IDLE;
    seq_next = (seq == IDLE) ? (audio_clk_en ? RUN : IDLE) :
               (seq == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  // slot walk: write back the shared datapath result, publish the whole bank after the last slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        v_r[i] <= '0;
        st_r[i] <= CHARGE;
        stage[i] <= '0;
        out_a[i] <= '0;
      end
    end else begin
      if (audio_clk_en && seq != IDLE) overrun <= 1'b1;
      idx <= (seq == RUN) ? idx + IW'(1) : '0;
      if (seq == RUN) begin
        v_r[idx] <= v_next;
        st_r[idx] <= st_next;
        stage[idx] <= sample;
        if (last) for (int i = 0; i < CHANNELS; i++) out_a[i] <= (IW'(i) == idx) ? sample : stage[i];
      end
    end
`ifdef VCO_CAP_OUT_EN
  logic [WIDTH-1:0] cap_stage [CHANNELS];
  logic [WIDTH-1:0] cap_a [CHANNELS];
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cap_pack
    assign cap_out[g*WIDTH +: WIDTH] = cap_a[g];
  end
  // capacitor voltage tap, staged and published alongside out
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cap_stage[i] <= '0;
        cap_a[i] <= '0;
      end
    end else if (seq == RUN) begin
      cap_stage[idx] <= v_next[VW-1:FRAC];
      if (last) for (int i = 0; i < CHANNELS; i++) cap_a[i] <= (IW'(i) == idx) ? v_next[VW-1:FRAC] : cap_stage[i];
    end
`endif
endmodule

// File: tb/tb_astable_555_vco_multi.sv
// tb_astable_555_vco_multi: scoreboard bench for the 2-channel VCO bank against a reference model
`timescale 1ns/1ps
module tb_astable_555_vco_multi;
  logic clk = 1'b0;
  logic reset;
  logic audio_clk_en;
  logic [1:0] chan_enable;
  logic [31:0] v_control;
  logic [31:0] out;
  logic out_valid, busy, overrun;
`ifdef VCO_CAP_OUT_EN
  logic [31:0] cap_out;
  logic [31:0] cq[$];
  int cnz1 = 0;
`endif
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  longint mv[2];
  bit ms[2];
  bit mprev[2];
  int mnz[2];
  int medges[2];
  int vcount = 0;
  int nz[2];
  int dedges[2];
  bit dprev[2];

  astable_555_vco_multi #(.CHANNELS(2)) dut (
    .clk(clk),
    .reset(reset),
    .audio_clk_en(audio_clk_en),
    .chan_enable(chan_enable),
    .v_control(v_control),
    .out(out),
`ifdef VCO_CAP_OUT_EN
    .cap_out(cap_out),
`endif
    .out_valid(out_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input int c, input int vc, input bit en);
    longint vmax = 64'hFFFFFF;
    longint u = longint'(vc) * 256;
    if (!en) begin
      mv[c] = 0;
      ms[c] = 0;
    end else if (vc == 0 || ms[c]) begin
      mv[c] = mv[c] - (mv[c] * 4096) / 65536;
      ms[c] = !(vc != 0 && mv[c] <= u / 2);
    end else begin
      mv[c] = mv[c] + ((vmax - mv[c]) * 2048) / 65536;
      if (mv[c] > vmax) mv[c] = vmax;
      ms[c] = mv[c] >= u;
    end
    return (en && !ms[c]) ? 16'h7fff : 16'h0000;
  endfunction

  task automatic push_expected();
    logic [31:0] e;
    logic [31:0] ce;
    logic [15:0] o;
    for (int c = 0; c < 2; c++) begin
      o = model_step(c, int'(v_control[c*16 +: 16]), chan_enable[c]);
      e[c*16 +: 16] = o;
      ce[c*16 +: 16] = 16'(mv[c] >> 8);
      if (o != 0) mnz[c]++;
      if (o != 0 && !mprev[c]) medges[c]++;
      mprev[c] = (o != 0);
    end
    q.push_back(e);
`ifdef VCO_CAP_OUT_EN
    cq.push_back(ce);
`endif
  endtask

  task automatic do_sample(input int period);
    @(posedge clk); #1 audio_clk_en = 1'b1;
    push_expected();
    @(posedge clk); #1 audio_clk_en = 1'b0;
    repeat (period - 2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && out_valid) begin
      vcount++;
      if (q.size() == 0) check("sb_unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("sb_out", out, e);
      end
`ifdef VCO_CAP_OUT_EN
      if (cq.size() != 0) begin
        e = cq.pop_front();
        check("sb_cap", cap_out, e);
      end
      if (cap_out[31:16] != 0) cnz1++;
`endif
      for (int c = 0; c < 2; c++) begin
        if (out[c*16 +: 16] != 0) nz[c]++;
        if (out[c*16 +: 16] != 0 && !dprev[c]) dedges[c]++;
        dprev[c] = out[c*16 +: 16] != 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, m0, m1, d0, d1, n0, mfirst, dfirst, mb, db;
    reset = 1'b1;
    audio_clk_en = 1'b0;
    chan_enable = 2'b11;
    v_control = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    v_control = {16'd32767, 16'd32767};
    @(posedge clk); #1 audio_clk_en = 1'b1;
    push_expected();
    @(posedge clk); #1 audio_clk_en = 1'b0;
    check("lat_busy_c1", busy, 1);
    check("lat_valid_c1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_busy_c2", busy, 1);
    check("lat_valid_c2", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid_c3", out_valid, 1);
    check("lat_busy_c3", busy, 0);
    check("lat_out_c3", out, 32'h7fff7fff);
    @(posedge clk); #1;
    check("lat_valid_c4", out_valid, 0);

    @(posedge clk); #1 audio_clk_en = 1'b1;
    push_expected();
    @(posedge clk); #1 audio_clk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_overrun", overrun, 0);
    q.delete();
`ifdef VCO_CAP_OUT_EN
    cq.delete();
`endif
    for (int c = 0; c < 2; c++) begin
      mv[c] = 0;
      ms[c] = 0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) do_sample(6);

    check("ovr_pre", overrun, 0);
    b0 = vcount;
    @(posedge clk); #1 audio_clk_en = 1'b1;
    push_expected();
    @(posedge clk); #1;
    @(posedge clk); #1 audio_clk_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("ovr_one_valid", vcount - b0, 1);
    check("ovr_flag", overrun, 1);

    v_control = {16'd10000, 16'd30000};
    b0 = dedges[0]; b1 = dedges[1]; m0 = medges[0]; m1 = medges[1];
    repeat (3000) do_sample(20);
    d0 = dedges[0] - b0; d1 = dedges[1] - b1; m0 = medges[0] - m0; m1 = medges[1] - m1;
    check("freq_ch0", (d0 >= m0 - 1 && d0 <= m0 + 1) ? m0 : d0, m0);
    check("freq_ch1", (d1 >= m1 - 1 && d1 <= m1 + 1) ? m1 : d1, m1);
    check("freq_order", d1 > d0, 1);

    v_control = {16'd10000, 16'd0};
    n0 = nz[0];
    repeat (1000) do_sample(6);
    check("zero_ch0_low", nz[0] - n0, 0);
    v_control[15:0] = 16'd20000;
    mfirst = -1;
    dfirst = -1;
    for (int k = 0; k < 60 && (mfirst < 0 || dfirst < 0); k++) begin
      mb = mnz[0];
      db = nz[0];
      do_sample(6);
      if (mfirst < 0 && mnz[0] > mb) mfirst = k;
      if (dfirst < 0 && nz[0] > db) dfirst = k;
    end
    check("zero_resume_seen", dfirst >= 0, 1);
    check("zero_resume_at", (dfirst >= mfirst - 1 && dfirst <= mfirst + 1) ? mfirst : dfirst, mfirst);

    chan_enable = 2'b01;
    v_control = {16'd30000, 16'd30000};
    n0 = nz[1];
    b0 = dedges[0];
`ifdef VCO_CAP_OUT_EN
    b1 = cnz1;
`endif
    repeat (500) do_sample(6);
    check("en_ch1_low", nz[1] - n0, 0);
    check("en_ch0_toggles", dedges[0] - b0 > 0, 1);
`ifdef VCO_CAP_OUT_EN
    check("en_cap1_zero", cnz1 - b1, 0);
`endif

    check("sb_drain", q.size(), 0);
    check("ovr_sticky", overrun, 1);
    reset = 1'b1;
    #1;
    check("ovr_cleared", overrun, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
